rv_regfile_sb: RTL and testbench

- Parametrised integer register file for the next core generation, with a load scoreboard.
- Replaces the flat register array with a configurable-width, configurable-depth, multi-read-port file.
- Reads are synchronous, with write-to-read bypass.
- A per-register pending bitmap tracks outstanding load writebacks and lets decode raise operand-hazard stalls.
- Sits between decode (read/scoreboard-set side) and writeback (write side).

---
 rtl/rv_regfile_sb.sv | 100 ++++++++++
 tb/tb_rv_regfile_sb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : rv_regfile_sb
// Brief    : Multi-port integer register file, x0 hardwired, with bypass and
//            a load-pending scoreboard for decode hazard stalls.
// Revision : 1.0
// ============================================================================
module rv_regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                flush,
    output logic                pending_any
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            pany_q;
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Set is applied after clear so a newly issued load wins over a retiring one.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wr_live)
                pend_d[wr_addr] = 1'b0;
            if (sb_set && (sb_addr != '0))
                pend_d[sb_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend_q <= '0;
            pany_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pany_q <= |pend_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int r = 0; r < NREG; r++)
                regs_q[r] <= '0;
        end else if (wr_live) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign pending_any = pany_q;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data_q;
            logic            hit;

            assign addr = rd_addr[i*AW +: AW];
            assign hit  = wr_live && (wr_addr == addr);

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    data_q <= '0;
                end else if (rd_en[i]) begin
                    if (addr == '0)
                        data_q <= '0;
                    else if (hit)
                        data_q <= wr_data;
                    else
                        data_q <= regs_q[addr];
                end
            end

            assign rd_data[i*XLEN +: XLEN] = data_q;
            assign rd_busy[i] = rd_en[i] && (addr != '0) && pend_q[addr] && !hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_regfile_sb
// Brief    : Directed plus randomized bench for rv_regfile_sb against a model.
// Revision : 1.0
// ============================================================================
module tb_rv_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = $clog2(NREG);

    logic                clk = 1'b0;
    logic                rstb;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                flush;
    logic                pending_any;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREG];
    logic [XLEN-1:0] m_rd   [NRD];
    logic            m_pend [NREG];
    logic            m_pany;

    always #5 clk = ~clk;

    rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .flush      (flush),
        .pending_any(pending_any)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int i);
        return rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] port_data(input int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        for (int i = 0; i < NRD; i++) m_rd[i] = '0;
        m_pany = 1'b0;
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // One clock: inputs already applied; checks busy now, registered outputs after the edge.
    task automatic cycle();
        logic [XLEN-1:0] nx_rd [NRD];
        logic            nx_pend [NREG];
        logic            any;
        int              a;
        #1;
        for (int i = 0; i < NRD; i++) begin
            a = int'(port_addr(i));
            check_eq($sformatf("busy%0d", i), 64'(rd_busy[i]),
                     64'(rd_en[i] && a != 0 && m_pend[a] && !(wr_en && int'(wr_addr) == a)));
        end
        for (int i = 0; i < NRD; i++) begin
            a = int'(port_addr(i));
            nx_rd[i] = m_rd[i];
            if (rd_en[i]) begin
                if (a == 0)                               nx_rd[i] = '0;
                else if (wr_en && int'(wr_addr) == a)     nx_rd[i] = wr_data;
                else                                      nx_rd[i] = m_regs[a];
            end
        end
        for (int r = 0; r < NREG; r++) nx_pend[r] = m_pend[r];
        if (flush) begin
            for (int r = 0; r < NREG; r++) nx_pend[r] = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0)  nx_pend[wr_addr] = 1'b0;
            if (sb_set && sb_addr != 0) nx_pend[sb_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        any = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            m_pend[r] = nx_pend[r];
            any |= nx_pend[r];
        end
        m_pany = any;
        for (int i = 0; i < NRD; i++) begin
            m_rd[i] = nx_rd[i];
            check_eq($sformatf("rd_data%0d", i), 64'(port_data(i)), 64'(m_rd[i]));
        end
        check_eq("pending_any", 64'(pending_any), 64'(m_pany));
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rstb = 1'b0;
        #12;
        check_eq("rst_rd0", 64'(port_data(0)), 64'h0);
        check_eq("rst_rd1", 64'(port_data(1)), 64'h0);
        check_eq("rst_pany", 64'(pending_any), 64'h0);
        @(negedge clk);
        rstb = 1'b1;

        // 1. read after reset
        set_rd(0, 5); set_rd(1, 5); cycle();
        check_eq("t1_rd0", 64'(port_data(0)), 64'h0);
        check_eq("t1_rd1", 64'(port_data(1)), 64'h0);

        // 2. write/read and x0
        idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hDEAD_BEEF; cycle();
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; cycle();
        idle(); set_rd(0, 3); set_rd(1, 0); cycle();
        check_eq("t2_rd0", 64'(port_data(0)), 64'hDEAD_BEEF);
        check_eq("t2_rd1", 64'(port_data(1)), 64'h0);
        idle(); rd_addr = {AW'(9), AW'(1)}; cycle();
        check_eq("t2_hold0", 64'(port_data(0)), 64'hDEAD_BEEF);

        // 3. bypass
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5_0001; set_rd(0, 7); set_rd(1, 7); cycle();
        check_eq("t3_rd0", 64'(port_data(0)), 64'hA5A5_0001);
        check_eq("t3_rd1", 64'(port_data(1)), 64'hA5A5_0001);

        // 4. load hazard
        idle(); sb_set = 1; sb_addr = 9; cycle();
        idle(); set_rd(0, 9); #1;
        check_eq("t4_busy", 64'(rd_busy[0]), 64'h1);
        cycle();
        check_eq("t4_pany", 64'(pending_any), 64'h1);
        wr_en = 1; wr_addr = 9; wr_data = 32'h42; #1;
        check_eq("t4_busy_wb", 64'(rd_busy[0]), 64'h0);
        cycle();
        check_eq("t4_rd0", 64'(port_data(0)), 64'h42);
        check_eq("t4_pany_clr", 64'(pending_any), 64'h0);

        // 5. simultaneous set/clear
        idle(); sb_set = 1; sb_addr = 4; cycle();
        idle(); sb_set = 1; sb_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 32'h0000_4444; cycle();
        idle(); set_rd(0, 4); #1;
        check_eq("t5_busy4", 64'(rd_busy[0]), 64'h1);
        cycle();
        check_eq("t5_rd4", 64'(port_data(0)), 64'h4444);
        idle(); sb_set = 1; sb_addr = 6; wr_en = 1; wr_addr = 4; wr_data = 32'h0000_5555; cycle();
        idle(); set_rd(0, 4); set_rd(1, 6); #1;
        check_eq("t5_busy4b", 64'(rd_busy[0]), 64'h0);
        check_eq("t5_busy6", 64'(rd_busy[1]), 64'h1);
        cycle();

        // 6. flush, then async reset mid-cycle
        for (int r = 2; r <= 4; r++) begin
            idle(); sb_set = 1; sb_addr = AW'(r); cycle();
        end
        idle(); flush = 1; sb_set = 1; sb_addr = 5; cycle();
        check_eq("t6_pany", 64'(pending_any), 64'h0);
        idle(); set_rd(0, 5); set_rd(1, 2); cycle();
        idle(); sb_set = 1; sb_addr = 8; wr_en = 1; wr_addr = 3; wr_data = 32'h3333;
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check_eq("t6_rst_rd0", 64'(port_data(0)), 64'h0);
        check_eq("t6_rst_rd1", 64'(port_data(1)), 64'h0);
        check_eq("t6_rst_pany", 64'(pending_any), 64'h0);
        @(negedge clk);
        idle();
        rstb = 1'b1;
        set_rd(0, 8); set_rd(1, 3); cycle();
        check_eq("t6_rd3", 64'(port_data(1)), 64'h0);
        idle(); set_rd(0, 7); cycle();

        // randomized traffic, addresses narrowed to force collisions
        for (int n = 0; n < 600; n++) begin
            idle();
            for (int i = 0; i < NRD; i++) begin
                rd_en[i] = 1'($urandom_range(0, 3) != 0);
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREG-1)
                                                                    : $urandom_range(0, 7));
            end
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            sb_set  = 1'($urandom_range(0, 2) == 0);
            sb_addr = AW'($urandom_range(0, 7));
            flush   = 1'($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
